register_file_mrnw: RTL and testbench
=====================================

REGISTER_FILE_MRNW -- requirements
Module: register_file_mrnw

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, word address width; NUM_WORDS = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-003 SHALL have parameter N_READ, default 3, number of combinational read ports, legal range 1..8.
REQ-004 SHALL have parameter N_WRITE, default 2, number of write ports, legal range 1..4.
REQ-005 SHALL have parameter ZERO_REG_EN, default 0; when 1, word 0 reads 0 and ignores writes.
REQ-006 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have raddr_i  input  N_READ*ADDR_WIDTH  read addresses; port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 SHALL have rdata_o  output  N_READ*DATA_WIDTH  read data; port k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have waddr_i  input  N_WRITE*ADDR_WIDTH  write addresses, packed as raddr_i.
REQ-011 SHALL have wdata_i  input  N_WRITE*DATA_WIDTH  write data, packed as rdata_o.
REQ-012 SHALL have we_i  input  N_WRITE  per-port write enable.
REQ-013 SHALL have clear_req_i  input  1  single-cycle pulse requesting a full zero-clear of the array.
REQ-014 SHALL have clear_busy_o  output  1  high while the clear sweep runs.
REQ-015 SHALL have wr_conflict_o  output  1  registered flag: previous cycle had two or more enabled write ports on one address.

Function
REQ-016 Reads SHALL be combinational: rdata_o port k equals the stored word at its address in the same cycle, zero latency.
REQ-017 Writes SHALL commit on the rising edge with we_i[j]=1; one cycle write-to-read latency without bypass.
REQ-018 Same-address multi-port writes SHALL resolve by highest port index winning; lower ports discarded for that word only.
REQ-019 wr_conflict_o SHALL assert the cycle after any collision of enabled write ports, deassert otherwise; writes to word 0 with ZERO_REG_EN=1 still count.
REQ-020 Controller SHALL be FSM IDLE/CLEAR; IDLE->CLEAR on clear_req_i=1; CLEAR->IDLE after the cycle writing index NUM_WORDS-1.
REQ-021 In CLEAR, an ADDR_WIDTH-bit counter SHALL start at 0, zero one word per cycle, increment by 1; sweep lasts exactly NUM_WORDS cycles.
REQ-022 clear_busy_o SHALL be high exactly while state is CLEAR, registered, rising the cycle after the clear_req_i pulse.
REQ-023 During CLEAR, all we_i SHALL be ignored and wr_conflict_o forced low; clear_req_i re-asserted during CLEAR is ignored (no restart).
REQ-024 During CLEAR, reads SHALL return current array contents (partially cleared state visible).
REQ-025 With ZERO_REG_EN=1, any read of address 0 SHALL return 0 regardless of writes or bypass.
REQ-026 Out-of-range parameters SHALL not be checked in RTL; behaviour undefined.

Reset
REQ-027 rst_n low SHALL asynchronously set all NUM_WORDS words to 0, state to IDLE, counter to 0, clear_busy_o to 0, wr_conflict_o to 0.
REQ-028 Reset asserted mid-sweep SHALL abort the sweep; after release, state is IDLE with no pending clear.
REQ-029 All rdata_o SHALL read 0 during and immediately after reset.

Configuration
REQ-030 Macro RF_WRITE_BYPASS_EN, when defined, SHALL make a read whose address matches an enabled write in the same cycle return the winning write data combinationally (outside CLEAR, address 0 excluded when ZERO_REG_EN=1).
REQ-031 Without RF_WRITE_BYPASS_EN, SHALL return the pre-write stored value in that cycle; no bypass logic is instantiated.

Verification
REQ-032 Reset then read all addresses on all ports -> every rdata_o = 0, clear_busy_o=0, wr_conflict_o=0.
REQ-033 Port0 writes 0xAAAA_0001 and port1 writes 0x5555_0002 to addr 7 same cycle -> next cycle addr 7 reads 0x5555_0002, wr_conflict_o=1 for one cycle.
REQ-034 Write 0x1234_5678 to addr 3 while port 2 reads addr 3 -> same cycle 0x1234_5678 with RF_WRITE_BYPASS_EN, old value 0 without; next cycle 0x1234_5678 both builds.
REQ-035 Fill all 32 words, pulse clear_req_i -> clear_busy_o high exactly 32 cycles, writes issued meanwhile discarded, afterwards all words read 0.
REQ-036 ZERO_REG_EN=1, write 0xDEAD_BEEF to addr 0 -> addr 0 reads 0 same and next cycle, also with bypass defined.
REQ-037 Assert rst_n low at sweep index 10, release -> clear_busy_o=0, all words 0, subsequent write/read to addr 31 works normally.

Source files
------------

// File: rtl/register_file_mrnw.sv
// Multi-read / multi-write register file with combinational reads and
// highest-port-wins write resolution. A two-state controller runs a
// one-word-per-cycle zero-clear sweep on request.
// Optional feature macro: RF_WRITE_BYPASS_EN. When it is defined, a read
// that hits an enabled write in the same cycle returns the winning write
// data. Without it, such a read returns the stored (pre-write) value.
module register_file_mrnw #(
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned N_READ      = 3,
    parameter int unsigned N_WRITE     = 2,
    parameter int unsigned ZERO_REG_EN = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_READ*ADDR_WIDTH-1:0]   raddr_i,
    output logic [N_READ*DATA_WIDTH-1:0]   rdata_o,
    input  logic [N_WRITE*ADDR_WIDTH-1:0]  waddr_i,
    input  logic [N_WRITE*DATA_WIDTH-1:0]  wdata_i,
    input  logic [N_WRITE-1:0]             we_i,
    input  logic                           clear_req_i,
    output logic                           clear_busy_o,
    output logic                           wr_conflict_o
);

    localparam int unsigned NUM_WORDS = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic [DATA_WIDTH-1:0]   mem      [NUM_WORDS];

    logic [ADDR_WIDTH-1:0]   raddr_a  [N_READ];
    logic [ADDR_WIDTH-1:0]   waddr_a  [N_WRITE];
    logic [DATA_WIDTH-1:0]   wdata_a  [N_WRITE];
    logic [DATA_WIDTH-1:0]   rd_word  [N_READ];
    logic [N_WRITE-1:0]      wr_ok_c;
    logic                    conflict_c;

    // Unpack the flat address/data buses into per-port arrays.
    always_comb begin
        for (int k = 0; k < N_READ; k++) begin
            raddr_a[k] = raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        end
        for (int j = 0; j < N_WRITE; j++) begin
            waddr_a[j] = waddr_i[j*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_a[j] = wdata_i[j*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Per-port effective write enable; word 0 is read-only when hardwired to zero.
    always_comb begin
        wr_ok_c = '0;
        for (int j = 0; j < N_WRITE; j++) begin
            wr_ok_c[j] = we_i[j] && !((ZERO_REG_EN != 0) && (waddr_a[j] == '0));
        end
    end

    // Collision detect on raw enables so hardwired word 0 still counts.
    always_comb begin
        conflict_c = 1'b0;
        for (int i = 0; i < N_WRITE; i++) begin
            for (int j = i + 1; j < N_WRITE; j++) begin
                if (we_i[i] && we_i[j] && (waddr_a[i] == waddr_a[j])) begin
                    conflict_c = 1'b1;
                end
            end
        end
    end

    // Clear controller: state, sweep counter and the registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            clr_cnt       <= '0;
            clear_busy_o  <= 1'b0;
            wr_conflict_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clr_cnt       <= '0;
                    // A collision on the request cycle would surface inside CLEAR, so drop it.
                    wr_conflict_o <= conflict_c && !clear_req_i;
                    if (clear_req_i) begin
                        state        <= CLEAR;
                        clear_busy_o <= 1'b1;
                    end
                end
                CLEAR: begin
                    wr_conflict_o <= 1'b0;
                    clr_cnt       <= clr_cnt + ADDR_WIDTH'(1);
                    if (clr_cnt == LAST_IDX) begin
                        state        <= IDLE;
                        clear_busy_o <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    clear_busy_o <= 1'b0;
                end
            endcase
        end
    end

    // Storage: sweep zeroes one word per cycle, otherwise later ports override earlier ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned w = 0; w < NUM_WORDS; w++) begin
                mem[ADDR_WIDTH'(w)] <= '0;
            end
        end else if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else begin
            for (int j = 0; j < N_WRITE; j++) begin
                if (wr_ok_c[j]) begin
                    mem[waddr_a[j]] <= wdata_a[j];
                end
            end
        end
    end

    // Combinational read path with optional same-cycle write forwarding.
    always_comb begin
        for (int k = 0; k < N_READ; k++) begin
            rd_word[k] = mem[raddr_a[k]];
`ifdef RF_WRITE_BYPASS_EN
            if (state == IDLE) begin
                for (int j = 0; j < N_WRITE; j++) begin
                    if (wr_ok_c[j] && (waddr_a[j] == raddr_a[k])) begin
                        rd_word[k] = wdata_a[j];
                    end
                end
            end
`endif
            if ((ZERO_REG_EN != 0) && (raddr_a[k] == '0)) begin
                rd_word[k] = '0;
            end
        end
    end

    // Repack per-port read words onto the flat output bus.
    always_comb begin
        rdata_o = '0;
        for (int k = 0; k < N_READ; k++) begin
            rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = rd_word[k];
        end
    end

endmodule

// File: tb/tb_register_file_mrnw.sv
// Directed testbench for register_file_mrnw: a main instance (default
// parameters) and a second instance with word 0 hardwired to zero, both
// driven by the same stimulus and checked against a scoreboard queue.
module tb_register_file_mrnw;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 3;
    localparam int unsigned NW = 2;
    localparam int NWORDS      = 32;

    logic              clk;
    logic              rst_n;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata;
    logic [NR*DW-1:0]  rdata_z;
    logic [NW*AW-1:0]  waddr;
    logic [NW*DW-1:0]  wdata;
    logic [NW-1:0]     we;
    logic              clear_req;
    logic              busy, busy_z;
    logic              conf, conf_z;

    register_file_mrnw u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .raddr_i       (raddr),
        .rdata_o       (rdata),
        .waddr_i       (waddr),
        .wdata_i       (wdata),
        .we_i          (we),
        .clear_req_i   (clear_req),
        .clear_busy_o  (busy),
        .wr_conflict_o (conf)
    );

    register_file_mrnw #(.ZERO_REG_EN(1)) u_dut_z (
        .clk           (clk),
        .rst_n         (rst_n),
        .raddr_i       (raddr),
        .rdata_o       (rdata_z),
        .waddr_i       (waddr),
        .wdata_i       (wdata),
        .we_i          (we),
        .clear_req_i   (clear_req),
        .clear_busy_o  (busy_z),
        .wr_conflict_o (conf_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    string       step = "init";
    logic [31:0] m  [NWORDS];
    logic [31:0] mz [NWORDS];
    bit          m_clear;
    int          m_cnt;
    bit          m_conf;
    int          busy_cnt;

    function automatic string kname(int kind);
        case (kind)
            0: return "rdata";
            1: return "clear_busy";
            2: return "wr_conflict";
            3: return "rdata_z";
            4: return "clear_busy_z";
            5: return "wr_conflict_z";
            default: return "unknown";
        endcase
    endfunction

    function automatic logic [31:0] observe(int kind, int idx);
        case (kind)
            0: return rdata[idx*32 +: 32];
            1: return {31'b0, busy};
            2: return {31'b0, conf};
            3: return rdata_z[idx*32 +: 32];
            4: return {31'b0, busy_z};
            5: return {31'b0, conf_z};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Expected read value for the current cycle's inputs and model state.
    function automatic logic [31:0] exp_rd(int a, bit z);
        if (z && a == 0) return 32'h0;
`ifdef RF_WRITE_BYPASS_EN
        if (!m_clear) begin
            if (we[1] && waddr[9:5] == 5'(a)) return wdata[63:32];
            if (we[0] && waddr[4:0] == 5'(a)) return wdata[31:0];
        end
`endif
        return z ? mz[a] : m[a];
    endfunction

    task automatic push(int kind, int idx, logic [31:0] v);
        exp_t e;
        e.kind = kind;
        e.idx  = idx;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s %s observed=%h expected=%h", step, tag, obs, expv);
        end
    endtask

    task automatic check_q();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.kind, e.idx);
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s %s[%0d] observed=%h expected=%h",
                       step, kname(e.kind), e.idx, obs, e.val);
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NWORDS; i++) begin
            m[i]  = 32'h0;
            mz[i] = 32'h0;
        end
        m_clear = 1'b0;
        m_cnt   = 0;
        m_conf  = 1'b0;
    endtask

    // Advance the reference model by one rising edge using the driven inputs.
    task automatic model_update();
        bit coll;
        coll = (we == 2'b11) && (waddr[4:0] == waddr[9:5]);
        if (!m_clear) begin
            m_conf = coll;
            if (we[0]) begin
                m[waddr[4:0]] = wdata[31:0];
                if (waddr[4:0] != 5'd0) mz[waddr[4:0]] = wdata[31:0];
            end
            if (we[1]) begin
                m[waddr[9:5]] = wdata[63:32];
                if (waddr[9:5] != 5'd0) mz[waddr[9:5]] = wdata[63:32];
            end
            if (clear_req) begin
                m_clear = 1'b1;
                m_cnt   = 0;
            end
        end else begin
            m_conf    = 1'b0;
            m[m_cnt]  = 32'h0;
            mz[m_cnt] = 32'h0;
            if (m_cnt == NWORDS - 1) m_clear = 1'b0;
            m_cnt = (m_cnt + 1) % NWORDS;
        end
    endtask

    task automatic wr(int p, int a, logic [31:0] d);
        we[p]             = 1'b1;
        waddr[p*5 +: 5]   = 5'(a);
        wdata[p*32 +: 32] = d;
    endtask

    task automatic nowr();
        we = '0;
    endtask

    task automatic rd(int k, int a);
        raddr[k*5 +: 5] = 5'(a);
        push(0, k, exp_rd(a, 1'b0));
        push(3, k, exp_rd(a, 1'b1));
    endtask

    // One cycle: compare pending expectations, then step model across the edge.
    task automatic cyc();
        push(1, 0, {31'b0, m_clear});
        push(2, 0, {31'b0, m_conf});
        push(4, 0, {31'b0, m_clear});
        push(5, 0, {31'b0, m_conf});
        #1;
        check_q();
        @(posedge clk);
        if (rst_n) model_update();
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b1;
        raddr     = '0;
        waddr     = '0;
        wdata     = '0;
        we        = '0;
        clear_req = 1'b0;
        model_reset();

        // Reset: everything reads zero while rst_n is low.
        step = "reset";
        #2 rst_n = 1'b0;
        #1;
        rd(0, 0); rd(1, 5); rd(2, 31);
        push(1, 0, 32'h0); push(2, 0, 32'h0); push(4, 0, 32'h0); push(5, 0, 32'h0);
        check_q();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        step = "post_reset_sweep";
        for (int a = 0; a < NWORDS; a++) begin
            rd(0, a); rd(1, (a + 1) % NWORDS); rd(2, (a + 2) % NWORDS);
            cyc();
        end

        // Two ports hit address 7: port 1 wins, conflict flag for one cycle.
        step = "conflict_addr7";
        wr(0, 7, 32'hAAAA_0001);
        wr(1, 7, 32'h5555_0002);
        rd(0, 7);
`ifdef RF_WRITE_BYPASS_EN
        push(0, 0, 32'h5555_0002);
`else
        push(0, 0, 32'h0000_0000);
`endif
        cyc();
        nowr();
        rd(0, 7);
        push(0, 0, 32'h5555_0002);
        push(2, 0, 32'h1);
        push(5, 0, 32'h1);
        cyc();
        rd(0, 7);
        push(2, 0, 32'h0);
        cyc();

        // Write/read same address same cycle.
        step = "same_cycle_addr3";
        wr(0, 3, 32'h1234_5678);
        rd(2, 3);
`ifdef RF_WRITE_BYPASS_EN
        push(0, 2, 32'h1234_5678);
`else
        push(0, 2, 32'h0000_0000);
`endif
        cyc();
        nowr();
        rd(2, 3);
        push(0, 2, 32'h1234_5678);
        cyc();

        // Distinct addresses on both ports: no conflict.
        step = "dual_write";
        wr(0, 10, 32'h0101_0A0A);
        wr(1, 11, 32'h0202_0B0B);
        cyc();
        nowr();
        rd(0, 10); rd(1, 11);
        push(2, 0, 32'h0);
        cyc();

        // Hardwired word 0 on the second instance.
        step = "zero_reg";
        wr(1, 0, 32'hDEAD_BEEF);
        rd(0, 0);
        push(3, 0, 32'h0);
        cyc();
        nowr();
        rd(0, 0);
        push(3, 0, 32'h0);
        push(0, 0, 32'hDEAD_BEEF);
        cyc();
        wr(0, 0, 32'h0000_0001);
        wr(1, 0, 32'h0000_0002);
        rd(0, 0);
        cyc();
        nowr();
        rd(0, 0);
        push(5, 0, 32'h1);
        push(0, 0, 32'h0000_0002);
        cyc();

        // Fill all words, then sweep-clear while hammering writes.
        step = "fill";
        for (int i = 0; i < NWORDS / 2; i++) begin
            wr(0, 2 * i, $urandom);
            wr(1, 2 * i + 1, $urandom);
            rd(0, 2 * i);
            cyc();
        end
        nowr();
        for (int a = 0; a < NWORDS; a++) begin
            rd(0, a);
            cyc();
        end

        step = "clear_sweep";
        clear_req = 1'b1;
        cyc();
        busy_cnt = 0;
        for (int j = 0; j < NWORDS; j++) begin
            if (busy) busy_cnt++;
            clear_req = (j == 5);
            begin
                int a;
                a = int'($urandom_range(0, NWORDS - 1));
                wr(0, a, $urandom);
                wr(1, a, $urandom);
            end
            rd(0, j);
            rd(1, (j + NWORDS - 1) % NWORDS);
            rd(2, NWORDS - 1);
            cyc();
        end
        clear_req = 1'b0;
        nowr();
        chk("busy_cycles", 32'(busy_cnt), 32'd32);
        chk("busy_after_sweep", {31'b0, busy}, 32'h0);
        step = "after_clear";
        for (int a = 0; a < NWORDS; a++) begin
            rd(0, a); rd(1, a); rd(2, a);
            cyc();
        end

        // Reset in the middle of a sweep.
        step = "reset_mid_sweep_setup";
        wr(0, 31, 32'hCAFE_0031);
        wr(1, 5, 32'hCAFE_0005);
        cyc();
        nowr();
        clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        for (int j = 0; j < 10; j++) begin
            rd(0, 31); rd(1, 5);
            cyc();
        end
        step = "reset_mid_sweep";
        rst_n = 1'b0;
        model_reset();
        rd(0, 31); rd(1, 5); rd(2, 10);
        cyc();
        rst_n = 1'b1;
        step = "after_abort";
        for (int j = 0; j < 3; j++) begin
            rd(0, 31); rd(1, 5); rd(2, j);
            cyc();
        end
        for (int a = 0; a < NWORDS; a++) begin
            rd(1, a);
            cyc();
        end
        wr(0, 31, 32'h0BAD_F00D);
        rd(2, 31);
        cyc();
        nowr();
        rd(2, 31);
        push(0, 2, 32'h0BAD_F00D);
        push(3, 2, 32'h0BAD_F00D);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
